float_round_pipe: RTL and testbench

Parametrised, mode-selectable IEEE-754 rounding stage for the FP adder datapath, placed after the normaliser and before result writeback. It consumes a normalised sign/exponent/mantissa with guard and sticky bits and applies one of five rounding modes. It handles mantissa carry-out, exponent overflow per mode, and zero/special pass-through. It is a two-stage valid/ready pipeline with full backpressure and sustains one result per cycle.

---
 rtl/float_round_pipe_if.sv | 40 ++++
 rtl/float_round_pipe.sv | 177 +++++++++++++++++
 tb/tb_float_round_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/float_round_pipe_if.sv
// Valid/ready bundle for float_round_pipe: upstream word port and downstream result port.
//   in_*  : normalised sign/exp/mant with guard, sticky, zero class and rounding mode
//   out_* : rounded result with inexact/overflow flags
// master = producer/consumer side (testbench or datapath), slave = rounding stage.
interface float_round_pipe_if #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              in_guard;
  logic              in_sticky;
  logic              in_zero;
  logic [2:0]        in_mode;

  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MANT_W-1:0] out_mant;
  logic              out_inexact;
  logic              out_overflow;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_guard, in_sticky, in_zero, in_mode,
    input  in_ready,
    input  out_valid, out_sign, out_exp, out_mant, out_inexact, out_overflow,
    output out_ready
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_guard, in_sticky, in_zero, in_mode,
    output in_ready,
    output out_valid, out_sign, out_exp, out_mant, out_inexact, out_overflow,
    input  out_ready
  );
endinterface

// File: rtl/float_round_pipe.sv
// Two-stage IEEE-754 rounding stage (RNE/RTZ/RDN/RUP/RMM) with full valid/ready backpressure.
// Ports:
//   Clock  : rising-edge clock
//   Reset  : synchronous, active-high; clears both stages and all outputs
//   bus    : float_round_pipe_if slave (in_* upstream word, out_* rounded result)
// S1 classifies the word and decides the increment; S2 adds it, handles carry-out,
// overflow per mode, and zero/special pass-through. in_ready is combinational.
module float_round_pipe #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  float_round_pipe_if.slave bus
);
  localparam int unsigned       SUM_W     = MANT_W + 1;
  localparam logic [EXP_W-1:0]  EXP_ONES  = '1;
  localparam logic [EXP_W-1:0]  EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [MANT_W-1:0] MANT_ONES = '1;
  localparam logic [MANT_W-1:0] MANT_HID  = {1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [2:0]        MODE_RNE  = 3'b000;
  localparam logic [2:0]        MODE_RTZ  = 3'b001;
  localparam logic [2:0]        MODE_RDN  = 3'b010;
  localparam logic [2:0]        MODE_RUP  = 3'b011;
  localparam logic [2:0]        MODE_RMM  = 3'b100;

  // Stage 1 registers
  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [MANT_W-1:0] r_s1_mant;
  logic [2:0]        r_s1_mode;
  logic              r_s1_zero;
  logic              r_s1_special;
  logic              r_s1_inexact;
  logic              r_s1_inc;

  // Stage 2 (output) registers
  logic              r_out_valid;
  logic              r_out_sign;
  logic [EXP_W-1:0]  r_out_exp;
  logic [MANT_W-1:0] r_out_mant;
  logic              r_out_inexact;
  logic              r_out_overflow;

  logic              w_s1_ready;
  logic              w_s2_ready;
  logic              w_special;
  logic              w_gs;
  logic              w_inc;
  logic [SUM_W-1:0]  w_sum;
  logic              w_carry;
  logic [EXP_W-1:0]  w_rnd_exp;
  logic [MANT_W-1:0] w_rnd_mant;
  logic              w_ovf;
  logic              w_to_inf;
  logic              w_res_sign;
  logic [EXP_W-1:0]  w_res_exp;
  logic [MANT_W-1:0] w_res_mant;
  logic              w_res_inexact;
  logic              w_res_ovf;

  // Handshake: a stage is ready when empty or when its downstream will drain it
  assign w_s2_ready   = ~r_out_valid | bus.out_ready;
  assign w_s1_ready   = ~r_s1_valid | w_s2_ready;
  assign bus.in_ready = ~Reset & w_s1_ready;

  assign w_special = (bus.in_exp == EXP_ONES);
  assign w_gs      = bus.in_guard | bus.in_sticky;

  // Increment decision; zero and special words never round
  always_comb begin
    w_inc = 1'b0;
    case (bus.in_mode)
      MODE_RNE: w_inc = bus.in_guard & (bus.in_sticky | bus.in_mant[0]);
      MODE_RTZ: w_inc = 1'b0;
      MODE_RDN: w_inc = bus.in_sign & w_gs;
      MODE_RUP: w_inc = ~bus.in_sign & w_gs;
      MODE_RMM: w_inc = bus.in_guard;
      default:  w_inc = bus.in_guard & (bus.in_sticky | bus.in_mant[0]);
    endcase
    if (bus.in_zero || w_special) w_inc = 1'b0;
  end

  // Mantissa increment with carry-out renormalisation
  assign w_sum      = {1'b0, r_s1_mant} + SUM_W'(r_s1_inc);
  assign w_carry    = w_sum[MANT_W];
  assign w_rnd_exp  = w_carry ? (r_s1_exp + EXP_W'(1)) : r_s1_exp;
  assign w_rnd_mant = w_carry ? MANT_HID : w_sum[MANT_W-1:0];
  assign w_ovf      = (w_rnd_exp == EXP_ONES) && (r_s1_exp != EXP_ONES);

  // Direction of an overflowed result: infinity or largest finite
  always_comb begin
    w_to_inf = 1'b1;
    case (r_s1_mode)
      MODE_RTZ: w_to_inf = 1'b0;
      MODE_RUP: w_to_inf = ~r_s1_sign;
      MODE_RDN: w_to_inf = r_s1_sign;
      default:  w_to_inf = 1'b1;
    endcase
  end

  // Final result selection: zero, special pass-through, overflow, normal
  always_comb begin
    w_res_sign    = r_s1_sign;
    w_res_exp     = w_rnd_exp;
    w_res_mant    = w_rnd_mant;
    w_res_inexact = r_s1_inexact;
    w_res_ovf     = 1'b0;
    if (r_s1_zero) begin
      w_res_exp     = '0;
      w_res_mant    = '0;
      w_res_inexact = 1'b0;
    end else if (r_s1_special) begin
      w_res_exp     = r_s1_exp;
      w_res_mant    = r_s1_mant;
      w_res_inexact = 1'b0;
    end else if (w_ovf) begin
      w_res_ovf     = 1'b1;
      w_res_inexact = 1'b1;
      w_res_exp     = w_to_inf ? EXP_ONES : EXP_MAXF;
      w_res_mant    = w_to_inf ? '0 : MANT_ONES;
    end
  end

  // Pipeline registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_s1_valid     <= 1'b0;
      r_s1_sign      <= 1'b0;
      r_s1_exp       <= '0;
      r_s1_mant      <= '0;
      r_s1_mode      <= '0;
      r_s1_zero      <= 1'b0;
      r_s1_special   <= 1'b0;
      r_s1_inexact   <= 1'b0;
      r_s1_inc       <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_sign     <= 1'b0;
      r_out_exp      <= '0;
      r_out_mant     <= '0;
      r_out_inexact  <= 1'b0;
      r_out_overflow <= 1'b0;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_sign    <= bus.in_sign;
          r_s1_exp     <= bus.in_exp;
          r_s1_mant    <= bus.in_mant;
          r_s1_mode    <= bus.in_mode;
          r_s1_zero    <= bus.in_zero;
          r_s1_special <= w_special;
          r_s1_inexact <= w_gs;
          r_s1_inc     <= w_inc;
        end
      end
      if (w_s2_ready) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_sign     <= w_res_sign;
          r_out_exp      <= w_res_exp;
          r_out_mant     <= w_res_mant;
          r_out_inexact  <= w_res_inexact;
          r_out_overflow <= w_res_ovf;
        end
      end
    end
  end

  assign bus.out_valid    = r_out_valid;
  assign bus.out_sign     = r_out_sign;
  assign bus.out_exp      = r_out_exp;
  assign bus.out_mant     = r_out_mant;
  assign bus.out_inexact  = r_out_inexact;
  assign bus.out_overflow = r_out_overflow;
endmodule

// File: tb/tb_float_round_pipe.sv
// Scoreboard bench for float_round_pipe (MANT_W=24, EXP_W=8): directed test-plan vectors,
// backpressure and reset scenarios, then randomized words against a value-level rounding model.
module tb_float_round_pipe;
  localparam int unsigned MW = 24;
  localparam int unsigned EW = 8;
  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
    logic          g;
    logic          s;
    logic          zero;
    logic [2:0]    mode;
  } in_t;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
    logic          inexact;
    logic          ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   or_mode;      // 0: out_ready high, 1: random, 2: held low
  int   n_cmp = 0;
  int   n_bad = 0;
  int   occ = 0;
  int   stall_cnt = 0;
  res_t exp_q[$];

  float_round_pipe_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

  float_round_pipe #(.MANT_W(MW), .EXP_W(EW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: round the value mant + (G,S fraction) by mode, then renormalise
  function automatic res_t model(input in_t it);
    res_t r;
    int   rem;
    bit   up;
    int unsigned m;
    int   e;
    bit   inf;
    r = '0;
    r.sign = it.sign;
    if (it.zero) return r;
    if (it.exp == 8'hFF) begin
      r.exp  = it.exp;
      r.mant = it.mant;
      return r;
    end
    rem = 2 * int'(it.g) + int'(it.s);   // quarters of an ulp; 2 == exactly half
    case (it.mode)
      RTZ:     up = 1'b0;
      RDN:     up = it.sign && rem != 0;
      RUP:     up = !it.sign && rem != 0;
      RMM:     up = rem >= 2;
      default: up = rem > 2 || (rem == 2 && (it.mant % 2) == 1);
    endcase
    m = int'(it.mant) + int'(up);
    e = int'(it.exp);
    if (m == (1 << MW)) begin
      m = 1 << (MW - 1);
      e = e + 1;
    end
    r.inexact = rem != 0;
    if (e == 255) begin
      r.ovf = 1'b1;
      r.inexact = 1'b1;
      case (it.mode)
        RTZ:     inf = 1'b0;
        RUP:     inf = !it.sign;
        RDN:     inf = it.sign;
        default: inf = 1'b1;
      endcase
      e = inf ? 255 : 254;
      m = inf ? 0 : (1 << MW) - 1;
    end
    r.exp  = EW'(e);
    r.mant = MW'(m);
    return r;
  endfunction

  function automatic in_t mk(input logic sg, input logic [7:0] ex, input logic [23:0] mt,
                             input logic g, input logic s, input logic z, input logic [2:0] md);
    in_t it;
    it.sign = sg; it.exp = ex; it.mant = mt; it.g = g; it.s = s; it.zero = z; it.mode = md;
    return it;
  endfunction

  function automatic res_t rs(input logic sg, input logic [7:0] ex, input logic [23:0] mt,
                              input logic ix, input logic ov);
    res_t r;
    r.sign = sg; r.exp = ex; r.mant = mt; r.inexact = ix; r.ovf = ov;
    return r;
  endfunction

  function automatic in_t rand_item();
    in_t it;
    int  cls;
    cls = int'($urandom_range(0, 15));
    it.sign = 1'($urandom_range(0, 1));
    it.zero = (cls == 0);
    if (cls == 1)      it.exp = 8'hFF;
    else if (cls < 4)  it.exp = 8'hFE;
    else               it.exp = 8'($urandom_range(1, 253));
    if ($urandom_range(0, 3) == 0) it.mant = 24'hFFFFFF;
    else                           it.mant = 24'($urandom) | 24'h800000;
    it.g    = 1'($urandom_range(0, 1));
    it.s    = 1'($urandom_range(0, 1));
    it.mode = 3'($urandom_range(0, 7));
    return it;
  endfunction

  // Called at a negedge; returns at the negedge after the word is accepted
  task automatic drive(input in_t it, input res_t e);
    int guard;
    bus.in_sign   = it.sign;
    bus.in_exp    = it.exp;
    bus.in_mant   = it.mant;
    bus.in_guard  = it.g;
    bus.in_sticky = it.s;
    bus.in_zero   = it.zero;
    bus.in_mode   = it.mode;
    bus.in_valid  = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stuck 0 after %0d cycles", guard);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    idle();
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // out_ready changes just after the rising edge so it is stable at every sample point
  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor: sample mid-cycle, check ready/hold behaviour and pop the scoreboard on transfer
  always @(negedge clk) begin
    res_t cur;
    res_t e;
    logic held_v;
    res_t held_w;
    #1;
    cur = {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inexact, bus.out_overflow};
    if (rst) begin
      held_v = 1'b0;
      occ = 0;
    end else begin
      check("in_ready", 64'(bus.in_ready), 64'((occ < 2) || bus.out_ready));
      if (held_v) check("hold_stable", 64'({bus.out_valid, cur}), 64'({1'b1, held_w}));
      held_v = bus.out_valid && !bus.out_ready;
      held_w = cur;
      if (bus.in_valid && !bus.in_ready) stall_cnt++;
      if (bus.in_valid && bus.in_ready) occ++;
      if (bus.out_valid && bus.out_ready) begin
        occ--;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          check("out_word", 64'(cur), 64'(e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  it;
    res_t zres;
    rst     = 1'b1;
    or_mode = 0;
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
    bus.in_guard = 1'b0; bus.in_sticky = 1'b0; bus.in_zero = 1'b0; bus.in_mode = '0;
    zres = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_word", 64'({bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inexact,
                               bus.out_overflow}), 64'(zres));
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // First word: latency of two edges
    drive(mk(0, 8'h7F, 24'h800001, 1, 0, 0, RNE), rs(0, 8'h7F, 24'h800002, 1, 0));
    idle();
    #2;
    check("latency_s1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #2;
    check("latency_s2", 64'(bus.out_valid), 64'd1);
    @(negedge clk);

    // Directed test-plan vectors, back to back
    drive(mk(0, 8'h7F, 24'h800002, 1, 0, 0, RNE), rs(0, 8'h7F, 24'h800002, 1, 0));
    drive(mk(0, 8'h7F, 24'hFFFFFF, 1, 1, 0, RNE), rs(0, 8'h80, 24'h800000, 1, 0));
    drive(mk(0, 8'hFE, 24'hFFFFFF, 1, 0, 0, RNE), rs(0, 8'hFF, 24'h000000, 1, 1));
    drive(mk(0, 8'hFE, 24'hFFFFFF, 1, 0, 0, RUP), rs(0, 8'hFF, 24'h000000, 1, 1));
    drive(mk(0, 8'hFE, 24'hFFFFFF, 1, 0, 0, RMM), rs(0, 8'hFF, 24'h000000, 1, 1));
    drive(mk(0, 8'hFE, 24'hFFFFFF, 1, 0, 0, RTZ), rs(0, 8'hFE, 24'hFFFFFF, 1, 0));
    drive(mk(1, 8'hFE, 24'hFFFFFF, 1, 1, 0, RDN), rs(1, 8'hFF, 24'h000000, 1, 1));
    drive(mk(1, 8'h85, 24'h900000, 0, 1, 0, RDN), rs(1, 8'h85, 24'h900001, 1, 0));
    drive(mk(1, 8'h85, 24'h900000, 0, 1, 0, RUP), rs(1, 8'h85, 24'h900000, 1, 0));
    drive(mk(1, 8'h85, 24'h900000, 0, 1, 0, RTZ), rs(1, 8'h85, 24'h900000, 1, 0));
    drive(mk(1, 8'h85, 24'h900000, 0, 1, 0, RNE), rs(1, 8'h85, 24'h900000, 1, 0));
    drive(mk(0, 8'hFF, 24'hC00000, 1, 0, 0, RNE), rs(0, 8'hFF, 24'hC00000, 0, 0));
    drive(mk(1, 8'h55, 24'h123456, 1, 1, 1, RUP), rs(1, 8'h00, 24'h000000, 0, 0));
    drive(mk(0, 8'h7F, 24'h800001, 1, 0, 0, 3'd7), rs(0, 8'h7F, 24'h800002, 1, 0));
    drive(mk(0, 8'h10, 24'hA00000, 0, 0, 0, RUP), rs(0, 8'h10, 24'hA00000, 0, 0));
    drive(mk(0, 8'h10, 24'h800001, 0, 1, 0, RNE), rs(0, 8'h10, 24'h800001, 1, 0));
    drain();

    // Six back-to-back words with out_ready dropped for three cycles
    stall_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          it = rand_item();
          drive(it, model(it));
        end
        idle();
      end
      begin
        repeat (2) @(posedge clk);
        or_mode = 2;
        repeat (3) @(posedge clk);
        or_mode = 0;
      end
    join
    drain();
    check("bp_in_ready_fell", 64'(stall_cnt > 0), 64'd1);

    // Reset with two words in flight
    or_mode = 2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      it = rand_item();
      drive(it, model(it));
    end
    idle();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #2;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_word", 64'({bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inexact,
                                  bus.out_overflow}), 64'(zres));
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    or_mode = 0;
    #2;
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("no_stale_out", 64'(bus.out_valid), 64'd0);
    drive(mk(0, 8'h40, 24'hABCDEF, 1, 1, 0, RMM), rs(0, 8'h40, 24'hABCDF0, 1, 0));
    drain();

    // Randomized traffic with random gaps and random backpressure
    or_mode = 1;
    for (int i = 0; i < 300; i++) begin
      it = rand_item();
      drive(it, model(it));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge clk);
      end
    end
    or_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
